bsg_counter_up_down_variable_multi: RTL and testbench
=====================================================

// Module: bsg_counter_up_down_variable_multi
// PURPOSE
//  Bank of els_p independent up/down counters with variable per-cycle steps, e.g.
//  per-virtual-channel credit counters in a router or DMA. Per channel: configurable
//  overflow/underflow handling (saturate or wrap), sticky error flags and an
//  "available" threshold output. All channels share one clock and one reset.
// PARAMETERS
//  els_p        4   number of independent counters (>=1)
//  max_val_p    15  max count value per channel (>=1)
//  init_val_p   15  count value loaded on reset (0..max_val_p)
//  max_step_p   4   max up/down step per cycle (1..max_val_p)
//  saturate_p   1   1: clamp at 0/max_val_p; 0: wrap modulo (max_val_p+1)
//  threshold_p  1   avail_o[i] asserted when count_o[i] >= threshold_p (0..max_val_p)
//  step_width_lp = `BSG_WIDTH(max_step_p); ptr_width_lp = `BSG_WIDTH(max_val_p)
// PORTS
//  clk_i        in   1                     clock; single clock domain
//  reset_i      in   1                     synchronous, active-high reset
//  up_i         in   els_p*step_width_lp   per-channel increment, channel i at [i*step_width_lp+:step_width_lp]
//  down_i       in   els_p*step_width_lp   per-channel decrement, same packing
//  clear_err_i  in   1                     clears all sticky error flags
//  count_o      out  els_p*ptr_width_lp    per-channel count (registered)
//  avail_o      out  els_p                 count_o[i] >= threshold_p (comb. from count_o)
//  overflow_o   out  els_p                 sticky: channel i exceeded max_val_p
//  underflow_o  out  els_p                 sticky: channel i went below 0
// BEHAVIOUR
//  - Single clock clk_i; reset_i is synchronous and active-high.
//  - Reset: every count = init_val_p; overflow_o = underflow_o = 0; avail_o follows count.
//    Reset overrides all other inputs, including mid-operation.
//  - Per channel, each cycle: next = count - down + up, evaluated signed at
//    ptr_width_lp+step_width_lp+1 bits. Only the net value matters: count=0, down=1,
//    up=1 leaves count 0 with no underflow.
//  - next > max_val_p: overflow event. saturate_p=1: count <= max_val_p;
//    saturate_p=0: count <= next-(max_val_p+1).
//  - next < 0: underflow event. saturate_p=1: count <= 0;
//    saturate_p=0: count <= next+(max_val_p+1).
//  - Otherwise count <= next. Latency: 1 cycle, inputs to count_o.
//  - up_i/down_i > max_step_p is illegal: simulation error, behaviour undefined.
//  - Sticky flags: an event sets the flag at the same edge as the count update, so it
//    is visible next cycle. clear_err_i clears all flags of all channels; an event in
//    the same cycle wins (flag stays 1).
//  - Channels are fully independent: an event on one channel never affects another.
//  - Simulation only: $error on illegal parameters (init_val_p/threshold_p >
//    max_val_p, max_step_p outside 1..max_val_p); $display on every overflow or
//    underflow event while reset_i===0.
// TESTING (els_p=4, max_val_p=15, init_val_p=15, max_step_p=4, threshold_p=1 unless noted)
//  1 reset, up=down=0 -> all count_o=15, avail_o=4'b1111, overflow_o=underflow_o=0
//  2 ch0 down=4 for 4 cycles -> ch0: 11,7,3,0; underflow_o[0]=1 after the 4th edge;
//    avail_o[0]=0; ch1..3 stay 15, no flags
//  3 ch1 at 15, up=2 and down=2 -> ch1 stays 15, overflow_o[1]=0
//  4 saturate_p=0, ch2 at 14, up=3 -> ch2=1, overflow_o[2]=1;
//    ch2 at 1, down=3 -> ch2=14, underflow_o[2]=1
//  5 clear_err_i=1 in the same cycle as a new ch3 overflow -> overflow_o[3] stays 1;
//    next cycle clear_err_i=1 alone -> all flags 0
//  6 counts at 5 with flags set, reset_i for 1 cycle with up/down active ->
//    next cycle all counts 15, all flags 0

Source files
------------

// File: rtl/bsg_counter_up_down_variable_multi.sv
// Bank of independent up/down counters with per-channel sticky over/underflow flags.
// One-cycle latency from up/down inputs to count; there is no backpressure, and all inputs are accepted every cycle.
module bsg_counter_up_down_variable_multi #(
  parameter int els_p       = 4,
  parameter int max_val_p   = 15,
  parameter int init_val_p  = 15,
  parameter int max_step_p  = 4,
  parameter int saturate_p  = 1,
  parameter int threshold_p = 1,
  localparam int step_width_lp = $clog2(max_step_p + 1),
  localparam int ptr_width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [els_p*step_width_lp-1:0]    up_i,
  input  logic [els_p*step_width_lp-1:0]    down_i,
  input  logic                              clear_err_i,
  output logic [els_p*ptr_width_lp-1:0]     count_o,
  output logic [els_p-1:0]                  avail_o,
  output logic [els_p-1:0]                  overflow_o,
  output logic [els_p-1:0]                  underflow_o
);

  localparam int sum_w_lp = ptr_width_lp + step_width_lp + 1;
  localparam logic signed [sum_w_lp-1:0] max_s_lp = sum_w_lp'(max_val_p);
  localparam logic [ptr_width_lp-1:0] mod_lp    = ptr_width_lp'(max_val_p + 1);
  localparam logic [ptr_width_lp-1:0] max_lp    = ptr_width_lp'(max_val_p);
  localparam logic [ptr_width_lp-1:0] init_lp   = ptr_width_lp'(init_val_p);
  localparam logic [ptr_width_lp-1:0] thresh_lp = ptr_width_lp'(threshold_p);

  logic [els_p-1:0][ptr_width_lp-1:0] r_count;
  logic [els_p-1:0][ptr_width_lp-1:0] w_count_nxt;
  logic [els_p-1:0] r_ovf, r_unf;
  logic [els_p-1:0] w_ovf, w_unf;

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    logic [step_width_lp-1:0]   w_up, w_dn;
    logic signed [sum_w_lp-1:0] w_sum;
    logic [ptr_width_lp-1:0]    w_wrap_hi, w_wrap_lo;

    assign w_up  = up_i[i*step_width_lp +: step_width_lp];
    assign w_dn  = down_i[i*step_width_lp +: step_width_lp];
    // Wide enough that count - down + up never wraps; the sign bit flags underflow.
    assign w_sum = sum_w_lp'(r_count[i]) - sum_w_lp'(w_dn) + sum_w_lp'(w_up);

    assign w_unf[i] = w_sum[sum_w_lp-1];
    assign w_ovf[i] = !w_sum[sum_w_lp-1] && (w_sum > max_s_lp);

    // Any wrapped result lies in 0..max_val_p, so the low bits alone suffice.
    assign w_wrap_hi = w_sum[ptr_width_lp-1:0] - mod_lp;
    assign w_wrap_lo = w_sum[ptr_width_lp-1:0] + mod_lp;

    assign w_count_nxt[i] = w_ovf[i] ? ((saturate_p != 0) ? max_lp : w_wrap_hi)
                          : w_unf[i] ? ((saturate_p != 0) ? '0     : w_wrap_lo)
                          : w_sum[ptr_width_lp-1:0];

    assign avail_o[i] = (r_count[i] >= thresh_lp);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= {els_p{init_lp}};
      r_ovf   <= '0;
      r_unf   <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf | (r_ovf & {els_p{~clear_err_i}});
      r_unf   <= w_unf | (r_unf & {els_p{~clear_err_i}});
    end
  end

  assign count_o     = r_count;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_i && (init_val_p > max_val_p || threshold_p > max_val_p ||
                    max_step_p < 1 || max_step_p > max_val_p))
      $error("bsg_counter_up_down_variable_multi: illegal parameter combination");
    if (reset_i === 1'b0) begin
      for (int i = 0; i < els_p; i++) begin
        if (up_i[i*step_width_lp +: step_width_lp] > step_width_lp'(max_step_p) ||
            down_i[i*step_width_lp +: step_width_lp] > step_width_lp'(max_step_p))
          $error("bsg_counter_up_down_variable_multi: step above max_step_p on channel %0d", i);
        if (w_ovf[i]) $display("bsg_counter_up_down_variable_multi: overflow event on channel %0d", i);
        if (w_unf[i]) $display("bsg_counter_up_down_variable_multi: underflow event on channel %0d", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_counter_up_down_variable_multi.sv
// Bench for bsg_counter_up_down_variable_multi: a saturating and a wrapping instance.
module tb_bsg_counter_up_down_variable_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s, rst_w, clr_s, clr_w;
  logic [11:0] up_s, dn_s, up_w, dn_w;
  logic [15:0] cnt_s, cnt_w;
  logic [3:0]  av_s, ov_s, un_s, av_w, ov_w, un_w;

  bsg_counter_up_down_variable_multi #(.saturate_p(1)) dut_s (
    .clk_i(clk), .reset_i(rst_s), .up_i(up_s), .down_i(dn_s), .clear_err_i(clr_s),
    .count_o(cnt_s), .avail_o(av_s), .overflow_o(ov_s), .underflow_o(un_s));

  bsg_counter_up_down_variable_multi #(.saturate_p(0)) dut_w (
    .clk_i(clk), .reset_i(rst_w), .up_i(up_w), .down_i(dn_w), .clear_err_i(clr_w),
    .count_o(cnt_w), .avail_o(av_w), .overflow_o(ov_w), .underflow_o(un_w));

  typedef struct {
    bit          w;
    bit          rst;
    bit          clr;
    logic [11:0] up;
    logic [11:0] dn;
    logic [15:0] cnt;
    logic [3:0]  ovf;
    logic [3:0]  unf;
    logic [3:0]  av;
  } vec_t;

  typedef struct {
    bit          w;
    int          idx;
    logic [15:0] cnt;
    logic [3:0]  ovf;
    logic [3:0]  unf;
    logic [3:0]  av;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t mk(input bit w, input bit rst, input bit clr,
                              input logic [11:0] up, input logic [11:0] dn,
                              input logic [15:0] cnt, input logic [3:0] ovf,
                              input logic [3:0] unf, input logic [3:0] av);
    vec_t v;
    v.w = w; v.rst = rst; v.clr = clr; v.up = up; v.dn = dn;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.av = av;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus on the selected instance, hold the other idle, check after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    rst_s = 1'b0; clr_s = 1'b0; up_s = '0; dn_s = '0;
    rst_w = 1'b0; clr_w = 1'b0; up_w = '0; dn_w = '0;
    if (v.w) begin
      rst_w = v.rst; clr_w = v.clr; up_w = v.up; dn_w = v.dn;
    end else begin
      rst_s = v.rst; clr_s = v.clr; up_s = v.up; dn_s = v.dn;
    end
    e.w = v.w; e.idx = idx; e.cnt = v.cnt; e.ovf = v.ovf; e.unf = v.unf; e.av = v.av;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.w) begin
      chk("wrap.count", e.idx, cnt_w, e.cnt);
      chk("wrap.overflow", e.idx, 16'(ov_w), 16'(e.ovf));
      chk("wrap.underflow", e.idx, 16'(un_w), 16'(e.unf));
      chk("wrap.avail", e.idx, 16'(av_w), 16'(e.av));
    end else begin
      chk("sat.count", e.idx, cnt_s, e.cnt);
      chk("sat.overflow", e.idx, 16'(ov_s), 16'(e.ovf));
      chk("sat.underflow", e.idx, 16'(un_s), 16'(e.unf));
      chk("sat.avail", e.idx, 16'(av_s), 16'(e.av));
    end
  endtask

  initial begin
    rst_s = 1'b1; rst_w = 1'b1; clr_s = 1'b0; clr_w = 1'b0;
    up_s = '0; dn_s = '0; up_w = '0; dn_w = '0;

    // Saturating instance: reset, drain ch0 to underflow, net-zero at max, clear races.
    tbl.push_back(mk(0, 1, 0, 12'h0, 12'h0,            16'hFFFF, 4'h0, 4'h0, 4'hF));
    tbl.push_back(mk(0, 0, 0, 12'h0, pk(4, 0, 0, 0),   16'hFFFB, 4'h0, 4'h0, 4'hF));
    tbl.push_back(mk(0, 0, 0, 12'h0, pk(4, 0, 0, 0),   16'hFFF7, 4'h0, 4'h0, 4'hF));
    tbl.push_back(mk(0, 0, 0, 12'h0, pk(4, 0, 0, 0),   16'hFFF3, 4'h0, 4'h0, 4'hF));
    tbl.push_back(mk(0, 0, 0, 12'h0, pk(4, 0, 0, 0),   16'hFFF0, 4'h0, 4'h1, 4'hE));
    tbl.push_back(mk(0, 0, 0, pk(0, 2, 0, 0), pk(0, 2, 0, 0), 16'hFFF0, 4'h0, 4'h1, 4'hE));
    tbl.push_back(mk(0, 0, 1, pk(0, 0, 0, 1), 12'h0,   16'hFFF0, 4'h8, 4'h0, 4'hE));
    tbl.push_back(mk(0, 0, 1, 12'h0, 12'h0,            16'hFFF0, 4'h0, 4'h0, 4'hE));
    tbl.push_back(mk(0, 0, 0, pk(1, 0, 0, 0), pk(1, 0, 0, 0), 16'hFFF0, 4'h0, 4'h0, 4'hE));
    tbl.push_back(mk(0, 0, 0, pk(1, 0, 0, 0), 12'h0,   16'hFFF1, 4'h0, 4'h0, 4'hF));
    tbl.push_back(mk(0, 0, 0, 12'h0, pk(1, 0, 0, 0),   16'hFFF0, 4'h0, 4'h0, 4'hE));
    // Wrapping instance: modulo-16 overflow/underflow, clear with no event, net-zero at 0.
    tbl.push_back(mk(1, 1, 0, 12'h0, 12'h0,            16'hFFFF, 4'h0, 4'h0, 4'hF));
    tbl.push_back(mk(1, 0, 0, 12'h0, pk(0, 0, 1, 0),   16'hFEFF, 4'h0, 4'h0, 4'hF));
    tbl.push_back(mk(1, 0, 0, pk(0, 0, 3, 0), 12'h0,   16'hF1FF, 4'h4, 4'h0, 4'hF));
    tbl.push_back(mk(1, 0, 0, 12'h0, pk(0, 0, 3, 0),   16'hFEFF, 4'h4, 4'h4, 4'hF));
    tbl.push_back(mk(1, 0, 0, pk(4, 0, 0, 0), 12'h0,   16'hFEF3, 4'h5, 4'h4, 4'hF));
    tbl.push_back(mk(1, 0, 1, 12'h0, pk(3, 0, 0, 0),   16'hFEF0, 4'h0, 4'h0, 4'hE));
    tbl.push_back(mk(1, 0, 0, pk(1, 0, 0, 0), pk(1, 0, 0, 0), 16'hFEF0, 4'h0, 4'h0, 4'hE));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Walk every channel of the saturating instance to 5 with a flag set, then reset under load.
    apply(mk(0, 0, 0, pk(4, 0, 0, 4), pk(0, 4, 4, 0), 16'hFBB4, 4'h8, 4'h0, 4'hF), 100);
    apply(mk(0, 0, 0, pk(1, 0, 0, 0), pk(0, 4, 4, 4), 16'hB775, 4'h8, 4'h0, 4'hF), 101);
    apply(mk(0, 0, 0, 12'h0, pk(0, 2, 2, 4),          16'h7555, 4'h8, 4'h0, 4'hF), 102);
    apply(mk(0, 0, 0, 12'h0, pk(0, 0, 0, 2),          16'h5555, 4'h8, 4'h0, 4'hF), 103);
    apply(mk(0, 1, 0, pk(4, 4, 4, 4), pk(1, 1, 1, 1), 16'hFFFF, 4'h0, 4'h0, 4'hF), 104);
    apply(mk(0, 0, 0, 12'h0, pk(1, 0, 0, 0),          16'hFFFE, 4'h0, 4'h0, 4'hF), 105);

    chk("scoreboard.leftover", 200, 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
